pow_5_share_arbiter: RTL



---
 rtl/pow_5_arb_pkg.sv | 27 ++
 rtl/pow_5_share_arbiter_rr.sv | 33 +++
 rtl/pow_5_share_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pow_5_arb_pkg.sv
// Shared definitions for the pow_5 share arbiter: defaults, clog2 and the tag record.
package pow_5_arb_pkg;

  localparam int unsigned N_DEF   = 4;
  localparam int unsigned W_DEF   = 8;
  localparam int unsigned LAT_DEF = 4;

  // Widest requester ID supported (N up to 8).
  localparam int unsigned IDW_MAX = 3;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One shadow-pipeline entry: does this slot carry an operation, and whose is it.
  typedef struct packed {
    logic               vld;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/pow_5_share_arbiter_rr.sv
// Combinational round-robin arbiter: first requester after i_ptr (mod N) wins.
module rr_arbiter_n
  import pow_5_arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned IDW = clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_en,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_id
);

  // Scan offsets 1..N from the pointer so the last winner has lowest priority.
  always_comb begin
    logic        w_found;
    int unsigned w_idx;
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_id           = IDW'(w_idx);
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pow_5_share_arbiter.sv
// Shares one in-order pow_5 pipeline among N requesters with round-robin admission.
// A shadow tag shift register tracks each operation's owner so results return tagged.
// Optional grant statistics are compiled in when POW5_ARB_STATS_EN is defined.
module pow_5_share_arbiter
  import pow_5_arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned W   = W_DEF,
  parameter int unsigned LAT = LAT_DEF,
  parameter int unsigned IDW = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [N-1:0]     req_vld,
  input  logic [N*W-1:0]   req_arg,
  output logic [N-1:0]     req_rdy,
  output logic             pipe_arg_vld,
  output logic [W-1:0]     pipe_arg,
  input  logic             pipe_res_vld,
  input  logic [5*W-1:0]   pipe_res,
  output logic             res_vld,
  output logic [IDW-1:0]   res_id,
  output logic [5*W-1:0]   res,
  output logic             busy,
  output logic             tag_err
`ifdef POW5_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]   stat_sel,
  input  logic             stat_clr,
  output logic [15:0]      stat_cnt
`endif
);

  logic [IDW-1:0] r_ptr;
  logic           r_pipe_vld;
  logic [W-1:0]   r_pipe_arg;
  tag_t           r_tag [LAT+1];
  logic           r_res_vld;
  logic [IDW-1:0] r_res_id;
  logic [5*W-1:0] r_res;
  logic           r_tag_err;

  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gid;
  logic           w_any;
  logic [W-1:0]   w_arg;
  tag_t           w_tag0;
  tag_t           w_tail;
  logic           w_busy;
  logic           w_unused_tail_id;

  rr_arbiter_n #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .i_req   (req_vld),
    .i_ptr   (r_ptr),
    .i_en    (clk_en),
    .o_grant (w_grant),
    .o_id    (w_gid)
  );

  assign w_any   = |w_grant;
  assign w_arg   = req_arg[int'(w_gid)*W +: W];
  assign w_tag0  = '{vld: w_any, id: IDW_MAX'(w_gid)};
  assign w_tail  = r_tag[LAT];
  // Upper ID bits are zero when IDW < IDW_MAX.
  assign w_unused_tail_id = ^w_tail.id;

  // Round-robin pointer: remembers the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDW'(N - 1);
    end else if (w_any) begin
      r_ptr <= w_gid;
    end
  end

  // Datapath launch registers and tag shadow pipeline, advancing only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= 1'b0;
      r_pipe_arg <= '0;
      for (int i = 0; i <= LAT; i++) r_tag[i] <= '0;
    end else if (clk_en) begin
      r_pipe_vld <= w_any;
      if (w_any) r_pipe_arg <= w_arg;
      r_tag[0] <= w_tag0;
      for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Result capture; res_vld is a single-cycle pulse regardless of clk_en afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_vld <= 1'b0;
      r_res_id  <= '0;
      r_res     <= '0;
    end else begin
      r_res_vld <= 1'b0;
      if (clk_en && pipe_res_vld) begin
        r_res_vld <= 1'b1;
        r_res     <= pipe_res;
        r_res_id  <= w_tail.id[IDW-1:0];
      end
    end
  end

  // Sticky flag: datapath valid and shadow tag valid disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_err <= 1'b0;
    end else if (clk_en && (w_tail.vld != pipe_res_vld)) begin
      r_tag_err <= 1'b1;
    end
  end

  // Anything launched or still travelling through the shadow pipeline.
  always_comb begin
    w_busy = r_pipe_vld;
    for (int i = 0; i <= LAT; i++) w_busy = w_busy | r_tag[i].vld;
  end

`ifdef POW5_ARB_STATS_EN
  logic [15:0] r_cnt [N];

  // Per-requester saturating grant counters; clear beats a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_grant[i] && (r_cnt[i] != 16'hFFFF)) r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < N) ? r_cnt[stat_sel] : 16'd0;
`endif

  assign req_rdy      = w_grant;
  assign pipe_arg_vld = r_pipe_vld;
  assign pipe_arg     = r_pipe_arg;
  assign res_vld      = r_res_vld;
  assign res_id       = r_res_id;
  assign res          = r_res;
  assign busy         = w_busy;
  assign tag_err      = r_tag_err;

endmodule
